// File: rtl/decode_ctrl_pkg.sv
// rtl/decode_ctrl_pkg.sv - opcodes, control bit indices, FSM states for the decode stage
package decode_ctrl_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_LDM  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_STD  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_LDD  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_PUSH = 5'b01100;
    localparam logic [OPC_W-1:0] OP_POP  = 5'b01101;

    localparam int CB_MEM_RD = 0;
    localparam int CB_MEM_WR = 1;
    localparam int CB_PUSH   = 2;
    localparam int CB_POP    = 3;
    localparam int CB_LDD    = 4;
    localparam int CB_STD    = 5;
    localparam int CB_IMM    = 6;
    localparam int CB_WB     = 7;

    typedef enum logic {
        S_OP,
        S_IMM
    } state_e;

    // Opcodes whose following fetch word is an immediate rather than an instruction
    function automatic logic is_two_word(input logic [OPC_W-1:0] op);
        return (op == OP_LDM) || (op == OP_STD) || (op == OP_LDD);
    endfunction

endpackage

// File: rtl/decode_ctrl_comb.sv
// rtl/decode_ctrl_comb.sv - combinational opcode to 8-bit control vector decoder
module decode_ctrl_comb
    import decode_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] op,
    output logic [7:0]       ctrl
);

    logic g;

    // Stack/memory group is opcodes 011xx; remaining bits come from opcode sets
    always_comb begin
        g               = (op[4:2] == 3'b011);
        ctrl            = '0;
        ctrl[CB_MEM_RD] = g & op[0];
        ctrl[CB_MEM_WR] = g & ~op[0];
        ctrl[CB_PUSH]   = g & ~op[1] & ~op[0];
        ctrl[CB_POP]    = g & ~op[1] & op[0];
        ctrl[CB_LDD]    = g & op[1] & op[0];
        ctrl[CB_STD]    = g & op[1] & ~op[0];
        ctrl[CB_IMM]    = op inside {5'b00001, 5'b11111, 5'b11101, 5'b00011,
                                     5'b11100, 5'b00111, 5'b10100, 5'b10101};
        ctrl[CB_WB]     = (op[4:3] == 2'b10) ||
                          (op inside {5'b01101, 5'b01111, 5'b00101,
                                      5'b00111, 5'b00010, 5'b00000});
    end

endmodule

// File: rtl/decode_ctrl_seq.sv
// rtl/decode_ctrl_seq.sv - decode stage with immediate capture, output register and retire counter
module decode_ctrl_seq
    import decode_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OPC_MSB = 15,
    parameter int CTRL_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_word,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [INSTR_W-1:0] out_instr,
    output logic [INSTR_W-1:0] out_imm,
    output logic               out_has_imm,
    output logic [CNT_W-1:0]   retired_cnt
);

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_ctrl_q, out_ctrl_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [INSTR_W-1:0] out_imm_q, out_imm_d;
    logic               out_has_imm_q, out_has_imm_d;
    logic [INSTR_W-1:0] pend_instr_q, pend_instr_d;
    logic [7:0]         pend_ctrl_q, pend_ctrl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [OPC_W-1:0]   op;
    logic [7:0]         dec_ctrl;
    logic               accept;
    logic               consume;

    assign op = in_word[OPC_MSB -: OPC_W];

    decode_ctrl_comb u_dec (
        .op   (op),
        .ctrl (dec_ctrl)
    );

    assign in_ready = ~rst & ~flush & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid_q & out_ready;

    // Next-state: retire/consume first, then flush override, then word acceptance
    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_ctrl_d    = out_ctrl_q;
        out_instr_d   = out_instr_q;
        out_imm_d     = out_imm_q;
        out_has_imm_d = out_has_imm_q;
        pend_instr_d  = pend_instr_q;
        pend_ctrl_d   = pend_ctrl_q;
        cnt_d         = cnt_q;

        if (consume) begin
            out_valid_d = 1'b0;
            if (~&cnt_q) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (flush) begin
            state_d     = S_OP;
            out_valid_d = 1'b0;
            cnt_d       = cnt_q;
        end else if (accept) begin
            unique case (state_q)
                S_OP: begin
                    if (is_two_word(op)) begin
                        pend_instr_d = in_word;
                        pend_ctrl_d  = dec_ctrl;
                        state_d      = S_IMM;
                    end else begin
                        out_valid_d   = 1'b1;
                        out_ctrl_d    = dec_ctrl;
                        out_instr_d   = in_word;
                        out_imm_d     = '0;
                        out_has_imm_d = 1'b0;
                    end
                end
                S_IMM: begin
                    out_valid_d   = 1'b1;
                    out_ctrl_d    = pend_ctrl_q;
                    out_instr_d   = pend_instr_q;
                    out_imm_d     = in_word;
                    out_has_imm_d = 1'b1;
                    state_d       = S_OP;
                end
                default: state_d = S_OP;
            endcase
        end
    end

    // State and output register; reset clears every visible field
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_OP;
            out_valid_q   <= 1'b0;
            out_ctrl_q    <= '0;
            out_instr_q   <= '0;
            out_imm_q     <= '0;
            out_has_imm_q <= 1'b0;
            pend_instr_q  <= '0;
            pend_ctrl_q   <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_ctrl_q    <= out_ctrl_d;
            out_instr_q   <= out_instr_d;
            out_imm_q     <= out_imm_d;
            out_has_imm_q <= out_has_imm_d;
            pend_instr_q  <= pend_instr_d;
            pend_ctrl_q   <= pend_ctrl_d;
            cnt_q         <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ctrl    = CTRL_W'(out_ctrl_q);
    assign out_instr   = out_instr_q;
    assign out_imm     = out_imm_q;
    assign out_has_imm = out_has_imm_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// tb/tb_decode_ctrl_seq.sv - scoreboard bench for decode_ctrl_seq
module tb_decode_ctrl_seq;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_ctrl;
    logic [15:0] out_instr;
    logic [15:0] out_imm;
    logic        out_has_imm;
    logic [CNT_W-1:0] retired_cnt;

    decode_ctrl_seq #(.INSTR_W(16), .OPC_MSB(15), .CTRL_W(8), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word     (in_word),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_instr   (out_instr),
        .out_imm     (out_imm),
        .out_has_imm (out_has_imm),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  ctrl;
        logic [15:0] imm;
        logic        has;
    } pkt_t;

    pkt_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          m_cnt = 0;
    logic        mon_rdy = 1'b0;
    logic        started = 1'b0;
    logic        rst_prev = 1'b0;
    logic        pend_valid = 1'b0;
    logic [15:0] pend_word = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference control vector, built from the opcode tables
    function automatic logic [7:0] ref_ctrl(input logic [4:0] op);
        logic [7:0] c;
        case (op)
            5'b01100: c = 8'h06;   // PUSH: mem_wr, push
            5'b01101: c = 8'h09;   // POP: mem_rd, pop
            5'b01110: c = 8'h22;   // STD: mem_wr, std
            5'b01111: c = 8'h11;   // LDD: mem_rd, ldd
            default:  c = 8'h00;
        endcase
        if (op inside {5'b00001, 5'b11111, 5'b11101, 5'b00011, 5'b11100, 5'b00111, 5'b10100, 5'b10101})
            c = c | 8'h40;
        if ((op >= 5'b10000 && op <= 5'b10111) ||
            (op inside {5'b01101, 5'b01111, 5'b00101, 5'b00111, 5'b00010, 5'b00000}))
            c = c | 8'h80;
        return c;
    endfunction

    // Monitor: checks handshake, counter and presented packet; pops on consume
    always @(negedge clk) begin
        if (started) begin
            logic ev;
            ev = (exp_q.size() != 0);
            chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
            mon_rdy = !rst && !flush && (!ev || out_ready);
            chk("in_ready", {31'd0, in_ready}, {31'd0, mon_rdy});
            chk("retired_cnt", {28'd0, retired_cnt}, m_cnt);
            if (out_valid && ev) begin
                chk("out_ctrl", {24'd0, out_ctrl}, {24'd0, exp_q[0].ctrl});
                chk("out_instr", {16'd0, out_instr}, {16'd0, exp_q[0].instr});
                chk("out_imm", {16'd0, out_imm}, {16'd0, exp_q[0].imm});
                chk("out_has_imm", {31'd0, out_has_imm}, {31'd0, exp_q[0].has});
            end
            if (rst_prev && !out_valid) begin
                chk("rst_ctrl", {24'd0, out_ctrl}, 0);
                chk("rst_instr", {16'd0, out_instr}, 0);
                chk("rst_imm", {16'd0, out_imm}, 0);
                chk("rst_has_imm", {31'd0, out_has_imm}, 0);
            end
            if (rst) begin
                exp_q.delete();
                m_cnt = 0;
            end else if (flush) begin
                exp_q.delete();
            end else if (ev && out_ready) begin
                void'(exp_q.pop_front());
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
            rst_prev = rst;
        end
    end

    // Predictor: turns accepted fetch words into expected packets
    always @(negedge clk) begin
        #1;
        if (started) begin
            if (rst || flush) begin
                pend_valid = 1'b0;
            end else if (in_valid && mon_rdy) begin
                if (pend_valid) begin
                    exp_q.push_back('{instr: pend_word, ctrl: ref_ctrl(pend_word[15:11]),
                                      imm: in_word, has: 1'b1});
                    pend_valid = 1'b0;
                end else if (in_word[15:11] inside {5'b00111, 5'b01110, 5'b01111}) begin
                    pend_word  = in_word;
                    pend_valid = 1'b1;
                end else begin
                    exp_q.push_back('{instr: in_word, ctrl: ref_ctrl(in_word[15:11]),
                                      imm: 16'h0, has: 1'b0});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        int   n;
        logic acc;
        n        = 0;
        in_valid = 1'b1;
        in_word  = w;
        do begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 expected accept of 0x%0h", w);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        started = 1'b1;
        #1;
        repeat (2) step();
        rst = 1'b0;
        out_ready = 1'b1;

        // Directed packets
        send(16'h6000);
        step();
        send(16'h7800);
        send(16'h1234);
        step();
        send(16'h6800);
        send(16'h0800);
        step();
        send(16'h3800);
        send(16'hABCD);
        send(16'h7000);
        send(16'h5555);
        step();

        // Stall with a word held, then release into same-cycle consume and accept
        out_ready = 1'b0;
        send(16'h6000);
        in_valid = 1'b1;
        in_word  = 16'h6800;
        repeat (3) step();
        out_ready = 1'b1;
        send(16'h6800);
        step();

        // Flush drops a pending STD opcode
        send(16'h7000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        send(16'h6000);
        step();

        // Flush against an unconsumed packet
        out_ready = 1'b0;
        send(16'h0800);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();

        // Reset in the middle of a two-word instruction
        send(16'h7800);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Counter saturation
        for (int i = 0; i < 17; i++) send(16'h6000);
        repeat (2) step();

        // Randomized traffic with occasional flush
        for (int c = 0; c < 3000; c++) begin
            logic acc;
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            flush     = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) == 0)
                    in_word = {5'b01100 + 5'($urandom_range(0, 3)), 11'($urandom)};
                else
                    in_word = 16'($urandom);
            end
        end

        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_seq.md
# decode_ctrl_seq

Sequential, parametrised instruction decode stage for the RISC core. It accepts instruction words from fetch over a valid/ready handshake and decodes the opcode field into the 8-bit control vector. For two-word instructions it captures the following word as the immediate. It presents one registered, stable decoded packet per instruction to the execute stage, supports pipeline flush, and counts retired packets.

## Interface
Parameters:
- INSTR_W, 16: instruction/immediate word width
- OPC_MSB, 15: MSB of the opcode field; the field is [OPC_MSB:OPC_MSB-4] (5 bits)
- CTRL_W, 8: control vector width; must be ≥8, bits above 7 are driven 0
- CNT_W, 16: retired-packet counter width

Ports:
- clk, in, 1: sole clock, rising edge
- rst, in, 1: synchronous, active-high reset
- flush, in, 1: discard the in-flight packet and any pending opcode
- in_valid, in, 1: fetch word valid
- in_ready, out, 1: stage accepts the word this cycle
- in_word, in, INSTR_W: instruction or immediate word
- out_valid, out, 1: decoded packet valid
- out_ready, in, 1: execute consumes the packet
- out_ctrl, out, CTRL_W: control vector
- out_instr, out, INSTR_W: first (opcode) word
- out_imm, out, INSTR_W: immediate word; 0 for one-word instructions
- out_has_imm, out, 1: packet is two-word
- retired_cnt, out, CNT_W: saturating count of consumed packets

## Operation
- Control bits, from opcode op = in_word[OPC_MSB:OPC_MSB-4]; g = (op[4:2]==3'b011):
  - [0] mem_rd = g & op[0]
  - [1] mem_wr = g & ~op[0]
  - [2] push = g & ~op[1] & ~op[0]
  - [3] pop = g & ~op[1] & op[0]
  - [4] ldd = g & op[1] & op[0]
  - [5] std = g & op[1] & ~op[0]
  - [6] imm/single-operand: op ∈ {00001, 11111, 11101, 00011, 11100, 00111, 10100, 10101}
  - [7] reg write-back: op[4:3]==10, or op ∈ {01101, 01111, 00101, 00111, 00010, 00000}
- Two-word opcodes: {00111 LDM, 01110 STD, 01111 LDD}. All other opcodes are one-word.
- FSM states:
  - S_OP: awaiting an opcode word.
  - S_IMM: opcode latched, awaiting the immediate word.
- S_OP transitions on an accepted word:
  - one-word opcode: load the output register (imm=0, has_imm=0), set out_valid.
  - two-word opcode: latch word and ctrl internally, go to S_IMM; out_valid is unaffected.
- S_IMM transition on an accepted word: the word becomes out_imm; load the output register with has_imm=1, set out_valid, return to S_OP. The word is never decoded as an opcode.
- in_ready = ~rst & ~flush & (~out_valid | out_ready). The same rule applies in both states.
- The output register holds all out_* fields stable while out_valid & ~out_ready.
- retired_cnt increments on out_valid & out_ready and saturates at all-ones.
- flush (sync, one cycle):
  - clears out_valid and returns the FSM to S_OP.
  - no word is accepted that cycle.
  - a pending opcode in S_IMM is dropped.
  - retired_cnt is unaffected.
  - flush has priority over a same-cycle consume: no increment.
- rst: state S_OP; all out_* = 0; retired_cnt = 0; in_ready = 0 during rst. Mid-packet reset discards everything.

## Timing
- One-word opcode accepted at edge N: out_valid high after edge N (visible in cycle N+1).
- Two-word packet: out_valid rises one cycle after the immediate is accepted.
- Simultaneous consume and accept: the new packet replaces the old with no bubble, giving a throughput of one packet per cycle.
- Two-word instructions need two accepts, so their throughput is one packet per two cycles.
- Output register is full and out_ready is low: in_ready is low, and in_word/in_valid must be held by fetch.

## Structure
- Package decode_ctrl_pkg holds:
  - opcode localparams (OP_LDM, OP_STD, OP_LDD, OP_PUSH, OP_POP, …) and control bit index constants.
  - the state enum {S_OP, S_IMM}.
  - the function is_two_word(op).
- One sub-module, decode_ctrl_comb: purely combinational op → ctrl[7:0] per the equations above. It is instantiated once, on in_word.

## Test plan
- 16'h6000 (PUSH), out_ready=1: next cycle out_ctrl=0x06, has_imm=0, imm=0; retired_cnt goes 0→1.
- 16'h7800 then 16'h1234: out_valid low after the first word; after the second, out_ctrl=0x91, out_imm=16'h1234, has_imm=1.
- Back-to-back 16'h6800 (POP), 16'h0800: out_ctrl 0x89 then 0x40 in consecutive cycles with out_ready=1; retired_cnt=2.
- 16'h3800 (LDM) → 0xC0 with imm; 16'h7000 (STD) → 0x22 with imm.
- Hold out_ready=0 for 3 cycles with out_valid high: in_ready=0 and all out_* stable. Release: consume plus a new accept occur in the same cycle.
- Send 16'h7000, then assert flush before the immediate, then send 16'h6000: output is 0x06 (not a STD); retired_cnt unchanged by the flush. Asserting rst mid-S_IMM forces all outputs to 0.
- Force retired_cnt to saturate (CNT_W=4, 17 packets): the counter stays at 4'hF.
